hdmi_video_timing: RTL and testbench



---
 rtl/hdmi_video_timing_if.sv | 14 +
 rtl/hdmi_video_timing.sv | 81 ++++++++
 tb/tb_hdmi_video_timing.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hdmi_video_timing_if.sv
// hdmi_video_timing_if: raster timing bus from the timing generator (master) to the
// pixel source / TMDS encoder (slave); en is the pixel-clock enable fed back to the generator.
interface hdmi_video_timing_if;
    logic        en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
    logic        line_start;
    logic        frame_start;
    modport master (input en, output hsync, vsync, de, x, y, line_start, frame_start);
    modport slave (output en, input hsync, vsync, de, x, y, line_start, frame_start);
endinterface

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: wrapping pixel/line counters with a registered one-cycle-late decode
// of sync, data-enable, coordinates and line/frame start pulses.
module hdmi_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input logic clk,
    input logic rst,
    hdmi_video_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_q, h_d, x_q, x_d;
    logic [10:0] v_q, v_d, y_q, y_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic        ls_q, ls_d, fs_q, fs_d;
    logic        h_wrap;

    // Outputs decode the pre-advance counter value, so they lag h/v by one enabled clk.
    always_comb begin
        h_wrap  = h_q == H_LAST;
        h_d     = vid.en ? (h_wrap ? '0 : h_q + 12'd1) : h_q;
        v_d     = (vid.en && h_wrap) ? (v_q == V_LAST ? '0 : v_q + 11'd1) : v_q;
        x_d     = vid.en ? h_q : x_q;
        y_d     = vid.en ? v_q : y_q;
        de_d    = vid.en ? (h_q < H_ACT && v_q < V_ACT) : de_q;
        hsync_d = vid.en ? ((h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL) : hsync_q;
        vsync_d = vid.en ? ((v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL) : vsync_q;
        ls_d    = vid.en && h_q == '0;
        fs_d    = vid.en && h_q == '0 && v_q == '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.de          = de_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: three raster generators (default mode, narrow-line default-vertical mode,
// tiny active-high mode) checked every cycle against a position-from-enable-count model.
module tb_hdmi_video_timing;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hdmi_video_timing_if ia ();
    hdmi_video_timing_if ib ();
    hdmi_video_timing_if ic ();

    hdmi_video_timing dut_a (.clk(clk), .rst(rst), .vid(ia));
    hdmi_video_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2)) dut_b (.clk(clk), .rst(rst), .vid(ib));
    hdmi_video_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1),
                        .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) dut_c (.clk(clk), .rst(rst), .vid(ic));

    logic [27:0] oa, ob, oc;
    assign oa = {ia.hsync, ia.vsync, ia.de, ia.line_start, ia.frame_start, ia.x, ia.y};
    assign ob = {ib.hsync, ib.vsync, ib.de, ib.line_start, ib.frame_start, ib.x, ib.y};
    assign oc = {ic.hsync, ic.vsync, ic.de, ic.line_start, ic.frame_start, ic.x, ic.y};

    int total = 0;
    int passed = 0;
    bit run = 1'b0;
    bit p1 = 1'b0;

    task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (hs vs de ls fs x y)", nm, act, exp);
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    // After n enabled clks the outputs show raster position n-1 (reset values when n==0).
    function automatic logic [27:0] model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                          input bit hp, vp, input int n, input bit l);
        int ht, vt, p, xx, yy;
        bit h, v;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (n == 0) return {~hp, ~vp, 3'b000, 12'd0, 11'd0};
        p  = (n - 1) % (ht * vt);
        xx = p % ht;
        yy = p / ht;
        h  = (xx >= ha + hf && xx < ha + hf + hs) ? hp : ~hp;
        v  = (yy >= va + vf && yy < va + vf + vs) ? vp : ~vp;
        return {h, v, (xx < ha && yy < va), (l && xx == 0), (l && xx == 0 && yy == 0), 12'(xx), 11'(yy)};
    endfunction

    int na = 0, nb = 0, nc = 0;
    bit la = 1'b0, lb = 1'b0, lc = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            na <= 0; nb <= 0; nc <= 0;
            la <= 1'b0; lb <= 1'b0; lc <= 1'b0;
        end else begin
            na <= na + int'(ia.en); la <= ia.en;
            nb <= nb + int'(ib.en); lb <= ib.en;
            nc <= nc + int'(ic.en); lc <= ic.en;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("model_a", oa, model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, na, la));
            check("model_b", ob, model(8, 2, 4, 2, 480, 10, 2, 33, 1'b0, 1'b0, nb, lb));
            check("model_c", oc, model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, nc, lc));
        end
    end

    int a_hs_cnt = 0, a_hs_first = -1, a_hs_last = -1, a_de_cnt = 0, a_ls_cnt = 0;
    int b_vs_cnt = 0, b_vs_fx = -1, b_vs_fy = -1, b_vs_lx = -1, b_vs_ly = -1, b_de_bad = 0, b_wrap = 0, b_prev_y = 0;
    int ccyc = 0, c_last = -1, c_d1 = -1, c_d2 = -1, c_run = 0, c_run_max = 0;
    int c_hs_min = 99, c_hs_max = -1, c_vs_min = 99, c_vs_max = -1;

    always @(negedge clk) begin
        if (p1) begin
            if (na >= 1 && na <= 800) begin
                if (!ia.hsync) begin
                    a_hs_cnt++;
                    if (a_hs_first < 0) a_hs_first = int'(ia.x);
                    a_hs_last = int'(ia.x);
                end
                if (ia.de) a_de_cnt++;
            end
            if (ia.line_start) a_ls_cnt++;
            if (nb >= 1 && nb <= 8400) begin
                if (!ib.vsync) begin
                    b_vs_cnt++;
                    if (b_vs_fx < 0) begin b_vs_fx = int'(ib.x); b_vs_fy = int'(ib.y); end
                    b_vs_lx = int'(ib.x); b_vs_ly = int'(ib.y);
                end
                if (ib.de && ib.y >= 11'd480) b_de_bad++;
            end
            if (b_prev_y == 524 && ib.y == 11'd0) b_wrap++;
            b_prev_y = int'(ib.y);
            ccyc++;
            if (ic.frame_start) begin
                if (c_last >= 0 && ccyc <= 280) c_d1 = ccyc - c_last;
                if (c_last >= 340) c_d2 = ccyc - c_last;
                c_last = ccyc;
            end
            if (ccyc <= 280 && nc >= 1) begin
                if (ic.hsync) begin
                    c_hs_min = (int'(ic.x) < c_hs_min) ? int'(ic.x) : c_hs_min;
                    c_hs_max = (int'(ic.x) > c_hs_max) ? int'(ic.x) : c_hs_max;
                end
                if (ic.vsync) begin
                    c_vs_min = (int'(ic.y) < c_vs_min) ? int'(ic.y) : c_vs_min;
                    c_vs_max = (int'(ic.y) > c_vs_max) ? int'(ic.y) : c_vs_max;
                end
            end
            if (ccyc > 320) begin
                c_run = ic.line_start ? c_run + 1 : 0;
                if (c_run > c_run_max) c_run_max = c_run;
            end
        end
    end

    initial begin
        int k;
        ia.en = 1'b0; ib.en = 1'b0; ic.en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_async_a", oa, 28'hC000000);
        check("reset_async_c", oc, 28'h0000000);
        run = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        ia.en = 1'b1; ib.en = 1'b1; ic.en = 1'b1;
        p1 = 1'b1;
        @(posedge clk);
        #1;
        check("first_out_a", oa, 28'hF800000);
        check("first_out_c", oc, 28'h3800000);
        k = 0;
        while (na != 16301 && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
            ic.en = (k < 300) ? 1'b1 : ~ic.en;
        end
        checki("reach_a_x300_y20", na, 16301);
        check("a_at_x300_y20", oa, {5'b11100, 12'd300, 11'd20});
        p1 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midframe_reset_a", oa, 28'hC000000);
        check("midframe_reset_b", ob, 28'hC000000);
        check("midframe_reset_c", oc, 28'h0000000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        ia.en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("hold_after_release_a", oa, 28'hC000000);
        ia.en = 1'b1;
        @(posedge clk);
        #1;
        check("restart_a", oa, 28'hF800000);
        repeat (1000) begin
            @(negedge clk);
            #1;
            ic.en = ~ic.en;
        end
        checki("a_hsync_low_clks", a_hs_cnt, 96);
        checki("a_hsync_first_x", a_hs_first, 656);
        checki("a_hsync_last_x", a_hs_last, 751);
        checki("a_de_clks_line0", a_de_cnt, 640);
        checki("a_line_starts", a_ls_cnt, 21);
        checki("b_vsync_low_clks", b_vs_cnt, 32);
        checki("b_vsync_first_x", b_vs_fx, 0);
        checki("b_vsync_first_y", b_vs_fy, 490);
        checki("b_vsync_last_x", b_vs_lx, 15);
        checki("b_vsync_last_y", b_vs_ly, 491);
        checki("b_de_in_vblank", b_de_bad, 0);
        checki("b_wrap_524_to_0", b_wrap, 1);
        checki("c_frame_len_en1", c_d1, 48);
        checki("c_frame_len_toggle", c_d2, 96);
        checki("c_hsync_min_x", c_hs_min, 5);
        checki("c_hsync_max_x", c_hs_max, 6);
        checki("c_vsync_min_y", c_vs_min, 4);
        checki("c_vsync_max_y", c_vs_max, 4);
        checki("c_pulse_width", c_run_max, 1);
        run = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
